// File: rtl/imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// imm_gen_pipe
//
// Pipelined immediate generator for the miniRV decode path. The immediate
// format is decoded from the opcode, the immediate is sign-extended to XLEN,
// pc + imm is computed, and the results are buffered in a small circular
// FIFO with valid/ready handshakes on both sides.
//
// Optional feature macro: IMM_Z_EN
//   defined   : CSRRWI/CSRRSI/CSRRCI (opcode 1110011, inst[14]=1) decode as
//               type Z with imm = zero-extended inst[19:15].
//   undefined : those instructions decode as I using the CSR field.
//
// Parameters:
//   XLEN   datapath width (32 or 64)
//   DEPTH  FIFO entries (power of two, >= 2)
//
// Ports:
//   cpu_clk     clock, rising edge
//   cpu_rst     synchronous active-high reset
//   flush       discard all buffered entries (priority over push/pop)
//   in_valid    inst/pc valid
//   in_ready    FIFO can accept an entry (registered state only)
//   inst        raw instruction word
//   pc          instruction address
//   out_valid   head entry valid
//   out_ready   consumer takes the head entry
//   out_imm     sign-extended immediate (0 while out_valid=0)
//   out_type    NONE=0 I=1 S=2 B=3 U=4 J=5 Z=6 (0 while out_valid=0)
//   out_target  pc + out_imm (0 while out_valid=0)
//   out_inst    instruction passed through (0 while out_valid=0)
//   level       current occupancy
// -----------------------------------------------------------------------------
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic                    cpu_clk,
  input  logic                    cpu_rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             inst,
  input  logic [XLEN-1:0]         pc,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         out_imm,
  output logic [2:0]              out_type,
  output logic [XLEN-1:0]         out_target,
  output logic [31:0]             out_inst,
  output logic [$clog2(DEPTH):0]  level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  localparam logic [2:0] T_NONE = 3'd0;
  localparam logic [2:0] T_I    = 3'd1;
  localparam logic [2:0] T_S    = 3'd2;
  localparam logic [2:0] T_B    = 3'd3;
  localparam logic [2:0] T_U    = 3'd4;
  localparam logic [2:0] T_J    = 3'd5;
`ifdef IMM_Z_EN
  localparam logic [2:0] T_Z    = 3'd6;
`endif

  // Extend a 32-bit value (already sign-correct in bit 31) to XLEN.
  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    logic [XLEN-1:0] r;
    r       = {XLEN{v[31]}};
    r[31:0] = v;
    return r;
  endfunction

  logic [2:0]       dec_type_s;
  logic [31:0]      dec_raw_s;
  logic [XLEN-1:0]  dec_imm_s;
  logic [XLEN-1:0]  dec_target_s;

  logic [XLEN-1:0]  imm_mem    [DEPTH];
  logic [2:0]       type_mem   [DEPTH];
  logic [XLEN-1:0]  target_mem [DEPTH];
  logic [31:0]      inst_mem   [DEPTH];

  logic [AW-1:0]    rd_ptr_r;
  logic [AW-1:0]    wr_ptr_r;
  logic [LW-1:0]    level_r;

  logic             push_s;
  logic             pop_s;
  logic             wr_en_s;

  // Opcode decode and immediate assembly; every format is first built as a
  // 32-bit value whose bit 31 carries the correct extension bit.
  always_comb begin
    dec_type_s = T_NONE;
    dec_raw_s  = 32'd0;
    case (inst[6:0])
      7'b0010011, 7'b0000011, 7'b1100111: begin
        dec_type_s = T_I;
        dec_raw_s  = {{20{inst[31]}}, inst[31:20]};
      end
      7'b1110011: begin
`ifdef IMM_Z_EN
        if (inst[14]) begin
          dec_type_s = T_Z;
          dec_raw_s  = {27'd0, inst[19:15]};
        end else begin
          dec_type_s = T_I;
          dec_raw_s  = {{20{inst[31]}}, inst[31:20]};
        end
`else
        dec_type_s = T_I;
        dec_raw_s  = {{20{inst[31]}}, inst[31:20]};
`endif
      end
      7'b0100011: begin
        dec_type_s = T_S;
        dec_raw_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      end
      7'b1100011: begin
        dec_type_s = T_B;
        dec_raw_s  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        dec_type_s = T_U;
        dec_raw_s  = {inst[31:12], 12'd0};
      end
      7'b1101111: begin
        dec_type_s = T_J;
        dec_raw_s  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      end
      default: begin
        dec_type_s = T_NONE;
        dec_raw_s  = 32'd0;
      end
    endcase
    dec_imm_s    = sext32(dec_raw_s);
    dec_target_s = pc + dec_imm_s;
  end

  // Handshake qualifiers; in_ready looks only at the occupancy register, so a
  // full FIFO never accepts even when it is popped in the same cycle.
  assign in_ready  = (level_r != LW'(DEPTH));
  assign out_valid = (level_r != LW'(0));
  assign push_s    = in_valid && in_ready;
  assign pop_s     = out_valid && out_ready;
  assign wr_en_s   = push_s && !flush && !cpu_rst;
  assign level     = level_r;

  // Pointer and occupancy bookkeeping; reset beats flush beats push/pop.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      rd_ptr_r <= AW'(0);
      wr_ptr_r <= AW'(0);
      level_r  <= LW'(0);
    end else if (flush) begin
      rd_ptr_r <= AW'(0);
      wr_ptr_r <= AW'(0);
      level_r  <= LW'(0);
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + LW'(1);
        2'b01:   level_r <= level_r - LW'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  // Entry storage; contents need no reset because the outputs are masked
  // whenever the FIFO is empty.
  always_ff @(posedge cpu_clk) begin
    if (wr_en_s) begin
      imm_mem[wr_ptr_r]    <= dec_imm_s;
      type_mem[wr_ptr_r]   <= dec_type_s;
      target_mem[wr_ptr_r] <= dec_target_s;
      inst_mem[wr_ptr_r]   <= inst;
    end
  end

  // Head-entry presentation, forced to zero while nothing is valid.
  always_comb begin
    if (out_valid) begin
      out_imm    = imm_mem[rd_ptr_r];
      out_type   = type_mem[rd_ptr_r];
      out_target = target_mem[rd_ptr_r];
      out_inst   = inst_mem[rd_ptr_r];
    end else begin
      out_imm    = '0;
      out_type   = 3'd0;
      out_target = '0;
      out_inst   = 32'd0;
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
module tb_imm_gen_pipe;

  localparam int XLEN  = 32;
  localparam int DEPTH = 2;

  logic              cpu_clk = 1'b0;
  logic              cpu_rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       inst;
  logic [XLEN-1:0]   pc;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_imm;
  logic [2:0]        out_type;
  logic [XLEN-1:0]   out_target;
  logic [31:0]       out_inst;
  logic [1:0]        level;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] imm;
    logic [2:0]  typ;
    logic [31:0] tgt;
    logic [31:0] ins;
  } entry_t;

  entry_t mq[$];
  entry_t obs[$];
  bit     last_push;

  always #5 cpu_clk = ~cpu_clk;

  imm_gen_pipe #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .inst(inst), .pc(pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
    .out_type(out_type), .out_target(out_target), .out_inst(out_inst),
    .level(level)
  );

  task automatic chk(input string tag, input logic [63:0] obsv, input logic [63:0] expv);
    checks++;
    assert (obsv === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obsv, expv);
    end
  endtask

  // Reference decode computed with integer field arithmetic.
  function automatic entry_t ref_dec(input logic [31:0] i, input logic [31:0] p);
    entry_t e;
    longint v;
    v = 0;
    e.typ = 3'd0;
    case (i[6:0])
      7'h13, 7'h03, 7'h67: begin e.typ = 3'd1; v = (i >> 20); if (v >= 2048) v -= 4096; end
      7'h73: begin
`ifdef IMM_Z_EN
        if (((i >> 14) & 1) == 1) begin e.typ = 3'd6; v = (i >> 15) & 31; end
        else begin e.typ = 3'd1; v = (i >> 20); if (v >= 2048) v -= 4096; end
`else
        e.typ = 3'd1; v = (i >> 20); if (v >= 2048) v -= 4096;
`endif
      end
      7'h23: begin e.typ = 3'd2; v = ((i >> 25) * 32) + ((i >> 7) & 31); if (v >= 2048) v -= 4096; end
      7'h63: begin
        e.typ = 3'd3;
        v = ((i >> 31) & 1) * 4096 + ((i >> 7) & 1) * 2048 + ((i >> 25) & 63) * 32 + ((i >> 8) & 15) * 2;
        if (v >= 4096) v -= 8192;
      end
      7'h37, 7'h17: begin e.typ = 3'd4; v = (i >> 12) * 4096; end
      7'h6F: begin
        e.typ = 3'd5;
        v = ((i >> 31) & 1) * 1048576 + ((i >> 12) & 255) * 4096 + ((i >> 20) & 1) * 2048 + ((i >> 21) & 1023) * 2;
        if (v >= 1048576) v -= 2097152;
      end
      default: begin e.typ = 3'd0; v = 0; end
    endcase
    e.imm = 32'(v);
    e.tgt = p + e.imm;
    e.ins = i;
    return e;
  endfunction

  // One clock: compare DUT against the model, then advance both.
  task automatic cycle(input bit do_chk);
    entry_t e;
    bit push_m, pop_m;
    e = '0;
    if (mq.size() != 0) e = mq[0];
    if (do_chk) begin
      chk("out_valid", out_valid, mq.size() != 0);
      chk("in_ready", in_ready, mq.size() != DEPTH);
      chk("level", level, mq.size());
      chk("out_imm", out_imm, e.imm);
      chk("out_type", out_type, e.typ);
      chk("out_target", out_target, e.tgt);
      chk("out_inst", out_inst, e.ins);
    end
    if (out_valid && out_ready && !cpu_rst && !flush)
      obs.push_back('{imm: out_imm, typ: out_type, tgt: out_target, ins: out_inst});
    push_m = in_valid && (mq.size() != DEPTH);
    pop_m  = (mq.size() != 0) && out_ready;
    last_push = push_m && !cpu_rst && !flush;
    if (cpu_rst || flush) begin
      mq.delete();
    end else begin
      if (pop_m) void'(mq.pop_front());
      if (push_m) mq.push_back(ref_dec(inst, pc));
    end
    @(posedge cpu_clk);
    #1;
  endtask

  logic [6:0] ops [10] = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};

  initial begin
    int accepted;
    cpu_rst = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    inst = 32'hFFF00093; pc = 32'd0;
    @(posedge cpu_clk); #1;
    cycle(1'b0);
    cycle(1'b0);
    cpu_rst = 1'b0; in_valid = 1'b0;
    mq.delete();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_level", level, 2'd0);
    chk("rst_out_imm", out_imm, 32'd0);

    // I-format
    inst = 32'hFFF00093; pc = 32'd0; in_valid = 1'b1;
    cycle(1'b1);
    in_valid = 1'b0;
    chk("i_valid", out_valid, 1'b1);
    chk("i_type", out_type, 3'd1);
    chk("i_imm", out_imm, 32'hFFFFFFFF);
    chk("i_target", out_target, 32'hFFFFFFFF);
    out_ready = 1'b1;
    cycle(1'b1);

    // B-format
    out_ready = 1'b0;
    inst = 32'hFE000EE3; pc = 32'h100; in_valid = 1'b1;
    cycle(1'b1);
    in_valid = 1'b0;
    chk("b_type", out_type, 3'd3);
    chk("b_imm", out_imm, 32'hFFFFFFFC);
    chk("b_target", out_target, 32'h000000FC);
    out_ready = 1'b1;
    cycle(1'b1);

    // Backpressure with three instructions
    out_ready = 1'b0; pc = 32'd0; obs.delete(); accepted = 0;
    inst = 32'h123450B7; in_valid = 1'b1;
    cycle(1'b1);
    inst = 32'h00112223;
    cycle(1'b1);
    chk("bp_in_ready", in_ready, 1'b0);
    chk("bp_level", level, 2'd2);
    inst = 32'h008000EF;
    cycle(1'b1);
    if (last_push) accepted++;
    cycle(1'b1);
    if (last_push) accepted++;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cycle(1'b1);
      if (last_push) begin accepted++; in_valid = 1'b0; end
    end
    in_valid = 1'b0;
    chk("bp_accept_once", accepted, 1);
    chk("bp_pops", obs.size(), 3);
    if (obs.size() == 3) begin
      chk("bp0_imm", obs[0].imm, 32'h12345000); chk("bp0_type", obs[0].typ, 3'd4);
      chk("bp1_imm", obs[1].imm, 32'h00000004); chk("bp1_type", obs[1].typ, 3'd2);
      chk("bp2_imm", obs[2].imm, 32'h00000008); chk("bp2_type", obs[2].typ, 3'd5);
    end

    // Flush while full, with a concurrent push attempt
    out_ready = 1'b0; in_valid = 1'b1; inst = 32'h00500093;
    cycle(1'b1);
    cycle(1'b1);
    chk("fl_level_before", level, 2'd2);
    flush = 1'b1;
    cycle(1'b1);
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_level", level, 2'd0);
    chk("fl_out_valid", out_valid, 1'b0);
    cycle(1'b1);

    // CSR immediate instruction
    inst = 32'h34015073; in_valid = 1'b1;
    cycle(1'b1);
    in_valid = 1'b0;
`ifdef IMM_Z_EN
    chk("z_type", out_type, 3'd6);
    chk("z_imm", out_imm, 32'h00000002);
`else
    chk("z_type", out_type, 3'd1);
    chk("z_imm", out_imm, 32'h00000340);
`endif
    out_ready = 1'b1;
    cycle(1'b1);

    // Randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 29) == 0);
      cpu_rst   = ($urandom_range(0, 79) == 0);
      inst      = $urandom;
      if ($urandom_range(0, 3) != 0) inst[6:0] = ops[$urandom_range(0, 9)];
      pc        = $urandom;
      cycle(1'b1);
    end
    cpu_rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    cycle(1'b1);
    cycle(1'b1);
    cycle(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
